// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite line-buffer write path.
package sprite_pkg;
   localparam int TILE_W      = 16;
   localparam int IDX_W       = $clog2(TILE_W);
   localparam int TRANSPARENT = 0;
   localparam int DEF_ADDR_W  = 9;
   localparam int DEF_PIX_W   = 4;

   typedef enum logic {IDLE, RUN} state_t;
endpackage

// File: rtl/sprite_pixel_select.sv
// Combinational tile-row pixel picker with horizontal flip and transparency flag.
module sprite_pixel_select
   import sprite_pkg::*;
#(
   parameter int PIX_W = DEF_PIX_W
) (
   input  logic [TILE_W*PIX_W-1:0] pixels,
   input  logic [IDX_W-1:0]        idx,
   input  logic                    flip,
   output logic [PIX_W-1:0]        pix,
   output logic                    transparent
);
   logic [IDX_W-1:0] src;

   always_comb begin
      // Bitwise inversion of a 4-bit index is 15-n.
      src         = flip ? ~idx : idx;
      pix         = pixels[32'(src)*PIX_W +: PIX_W];
      transparent = (pix == PIX_W'(TRANSPARENT));
   end
endmodule

// File: rtl/sprite_pixel_writer.sv
// Compacts one 16-pixel tile row into the sprite line buffer under a serial shrink-enable stream.
module sprite_pixel_writer
   import sprite_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int PIX_W  = DEF_PIX_W
) (
   input  logic                    CK,
   input  logic                    nRESET,
   input  logic                    LOAD,
   input  logic                    SHRINK_BIT,
   input  logic [ADDR_W-1:0]       X_START,
   input  logic [TILE_W*PIX_W-1:0] PIXELS,
   input  logic                    FLIP,
   output logic                    LB_WE,
   output logic [ADDR_W-1:0]       LB_ADDR,
   output logic [PIX_W-1:0]        LB_DATA,
   output logic                    BUSY,
   output logic                    DONE,
   output logic [4:0]              PIX_COUNT
);
   state_t state_q, state_d;
   logic   start, last, keep;

   logic [TILE_W*PIX_W-1:0] pix_row_p0;
   logic                    flip_p0;
   logic [ADDR_W-1:0]       x_ptr_p0;
   logic [IDX_W-1:0]        idx_p0;
   logic [4:0]              cnt_p0;

   logic [PIX_W-1:0]        sel_pix;
   logic                    sel_transparent;

   logic                    lb_we_p1;
   logic [ADDR_W-1:0]       lb_addr_p1;
   logic [PIX_W-1:0]        lb_data_p1;
   logic                    busy_p1;
   logic                    done_p1;
   logic [4:0]              pix_count_p1;

   sprite_pixel_select #(.PIX_W(PIX_W)) u_select (
      .pixels      (pix_row_p0),
      .idx         (idx_p0),
      .flip        (flip_p0),
      .pix         (sel_pix),
      .transparent (sel_transparent)
   );

   assign last = (state_q == RUN) && (idx_p0 == IDX_W'(TILE_W - 1));
   assign keep = (state_q == RUN) && SHRINK_BIT;

   always_ff @(posedge CK or negedge nRESET) begin
      if (!nRESET) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      start   = 1'b0;
      case (state_q)
         IDLE: begin
            if (LOAD) begin
               state_d = RUN;
               start   = 1'b1;
            end
         end
         RUN: begin
            if (last) begin
               if (LOAD) start   = 1'b1;
               else      state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Stage p0: tile capture, pixel index, X pointer and kept-pixel count.
   always_ff @(posedge CK or negedge nRESET) begin
      if (!nRESET) begin
         pix_row_p0 <= '0;
         flip_p0    <= 1'b0;
         x_ptr_p0   <= '0;
         idx_p0     <= '0;
         cnt_p0     <= '0;
      end else if (start) begin
         pix_row_p0 <= PIXELS;
         flip_p0    <= FLIP;
         x_ptr_p0   <= X_START;
         idx_p0     <= '0;
         cnt_p0     <= '0;
      end else if (state_q == RUN) begin
         idx_p0 <= idx_p0 + 1'b1;
         if (keep) begin
            x_ptr_p0 <= x_ptr_p0 + 1'b1;
            cnt_p0   <= cnt_p0 + 1'b1;
         end
      end
   end

   // Stage p1: registered line-buffer write port and tile status.
   always_ff @(posedge CK or negedge nRESET) begin
      if (!nRESET) begin
         lb_we_p1     <= 1'b0;
         lb_addr_p1   <= '0;
         lb_data_p1   <= '0;
         busy_p1      <= 1'b0;
         done_p1      <= 1'b0;
         pix_count_p1 <= '0;
      end else begin
         lb_we_p1 <= keep && !sel_transparent;
         if (keep) begin
            lb_addr_p1 <= x_ptr_p0;
            lb_data_p1 <= sel_pix;
         end
         busy_p1 <= (state_d == RUN);
         done_p1 <= last;
         if (last) pix_count_p1 <= cnt_p0 + 5'(keep);
      end
   end

   assign LB_WE     = lb_we_p1;
   assign LB_ADDR   = lb_addr_p1;
   assign LB_DATA   = lb_data_p1;
   assign BUSY      = busy_p1;
   assign DONE      = done_p1;
   assign PIX_COUNT = pix_count_p1;
endmodule

// File: tb/tb_sprite_pixel_writer.sv
// Self-checking bench for sprite_pixel_writer against a kept-pixel arithmetic model.
module tb_sprite_pixel_writer;
   logic        CK;
   logic        nRESET;
   logic        LOAD;
   logic        SHRINK_BIT;
   logic [8:0]  X_START;
   logic [63:0] PIXELS;
   logic        FLIP;
   logic        LB_WE;
   logic [8:0]  LB_ADDR;
   logic [3:0]  LB_DATA;
   logic        BUSY;
   logic        DONE;
   logic [4:0]  PIX_COUNT;

   sprite_pixel_writer #(.ADDR_W(9), .PIX_W(4)) dut (
      .CK         (CK),
      .nRESET     (nRESET),
      .LOAD       (LOAD),
      .SHRINK_BIT (SHRINK_BIT),
      .X_START    (X_START),
      .PIXELS     (PIXELS),
      .FLIP       (FLIP),
      .LB_WE      (LB_WE),
      .LB_ADDR    (LB_ADDR),
      .LB_DATA    (LB_DATA),
      .BUSY       (BUSY),
      .DONE       (DONE),
      .PIX_COUNT  (PIX_COUNT)
   );

   initial CK = 1'b0;
   always #5 CK = ~CK;

   int n_checks = 0;
   int n_errors = 0;

   // Model state that persists between tiles: held write port and last count.
   logic [8:0]  exp_addr;
   logic [3:0]  exp_data;
   logic [4:0]  exp_cnt;

   logic [8:0]  nxt_xs;
   logic [63:0] nxt_pix;
   logic        nxt_flp;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_checks++;
      if (obs !== expv) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
      end
   endtask

   function automatic logic [3:0] pix_of(input logic [63:0] p, input int k);
      return p[k*4 +: 4];
   endfunction

   function automatic logic [63:0] rand_pix();
      return {$urandom, $urandom};
   endfunction

   task automatic check_all_zero(input string tag);
      check({tag, "_we"},   LB_WE,     0);
      check({tag, "_addr"}, LB_ADDR,   0);
      check({tag, "_data"}, LB_DATA,   0);
      check({tag, "_busy"}, BUSY,      0);
      check({tag, "_done"}, DONE,      0);
      check({tag, "_cnt"},  PIX_COUNT, 0);
   endtask

   task automatic do_reset();
      nRESET = 1'b0;
      #1;
      check_all_zero("rst_async");
      exp_addr = '0;
      exp_data = '0;
      exp_cnt  = '0;
      LOAD     = 1'b0;
      repeat (2) begin
         @(posedge CK); #1;
         check("rst_hold_done", DONE, 0);
      end
      @(negedge CK);
      nRESET = 1'b1;
   endtask

   // Idle cycles with random shrink bits: nothing may be written or signalled.
   task automatic idle(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         @(negedge CK);
         LOAD       = 1'b0;
         SHRINK_BIT = 1'($urandom);
         X_START    = 9'($urandom);
         @(posedge CK); #1;
         check("idle_we",   LB_WE,     0);
         check("idle_addr", LB_ADDR,   exp_addr);
         check("idle_data", LB_DATA,   exp_data);
         check("idle_busy", BUSY,      0);
         check("idle_done", DONE,      0);
         check("idle_cnt",  PIX_COUNT, exp_cnt);
      end
   endtask

   // One tile. first: issue LOAD for E0 here (else the previous tile chained it).
   // chain: present nxt_* with LOAD on the last RUN edge. abort_at: reset before that pixel's edge.
   task automatic run_tile(input logic [8:0] xs, input logic [63:0] pix, input logic flp,
                           input logic [15:0] stream, input bit first, input bit chain,
                           input bit junk_load, input int abort_at);
      int k;
      bit b;
      logic exp_we;
      k = 0;
      if (first) begin
         @(negedge CK);
         LOAD       = 1'b1;
         X_START    = xs;
         PIXELS     = pix;
         FLIP       = flp;
         SHRINK_BIT = 1'($urandom);
         @(posedge CK); #1;
         check("e0_busy", BUSY, 1);
         check("e0_done", DONE, 0);
         check("e0_we",   LB_WE, 0);
      end
      for (int n = 0; n < 16; n++) begin
         @(negedge CK);
         b          = stream[15-n];
         LOAD       = (junk_load && n == 4) || (chain && n == 15);
         SHRINK_BIT = b;
         if (chain && n == 15) begin
            X_START = nxt_xs;
            PIXELS  = nxt_pix;
            FLIP    = nxt_flp;
         end else begin
            X_START = 9'($urandom);
            PIXELS  = rand_pix();
            FLIP    = 1'($urandom);
         end
         if (n == abort_at) begin
            do_reset();
            return;
         end
         @(posedge CK); #1;
         exp_we = 1'b0;
         if (b) begin
            exp_addr = xs + 9'(k);
            exp_data = pix_of(pix, flp ? 15 - n : n);
            exp_we   = (exp_data != 4'd0);
            k++;
         end
         check("lb_we",   LB_WE,   exp_we);
         check("lb_addr", LB_ADDR, exp_addr);
         check("lb_data", LB_DATA, exp_data);
         check("busy",    BUSY,    (n < 15) || chain);
         check("done",    DONE,    n == 15);
         if (n == 15) exp_cnt = 5'(k);
         check("pix_count", PIX_COUNT, exp_cnt);
      end
      if (!chain) begin
         @(negedge CK);
         LOAD       = 1'b0;
         SHRINK_BIT = 1'($urandom);
         @(posedge CK); #1;
         check("tail_we",   LB_WE,     0);
         check("tail_busy", BUSY,      0);
         check("tail_done", DONE,      0);
         check("tail_cnt",  PIX_COUNT, exp_cnt);
      end
   endtask

   logic [63:0] p;
   logic [8:0]  cur_xs;
   logic [63:0] cur_pix;
   logic        cur_flp;
   bit          prev_chain;
   bit          chain;

   initial begin
      nRESET     = 1'b0;
      LOAD       = 1'b0;
      SHRINK_BIT = 1'b0;
      X_START    = '0;
      PIXELS     = '0;
      FLIP       = 1'b0;
      exp_addr   = '0;
      exp_data   = '0;
      exp_cnt    = '0;
      #12;
      check_all_zero("reset");
      @(negedge CK);
      nRESET = 1'b1;
      idle(3);

      // All-keep, colours 1..F,1
      for (int k = 0; k < 16; k++) p[k*4 +: 4] = 4'((k % 15) + 1);
      run_tile(9'h010, p, 1'b0, 16'hFFFF, 1, 0, 0, -1);
      check("allkeep_cnt", PIX_COUNT, 16);
      idle(2);

      // Maximum shrink: only pixel 8 survives
      run_tile(9'h0A5, p, 1'b0, 16'h0080, 1, 0, 0, -1);
      check("maxshrink_cnt", PIX_COUNT, 1);

      // Address wrap with a transparent pixel 2
      for (int k = 0; k < 16; k++) p[k*4 +: 4] = 4'(($urandom % 15) + 1);
      p[8 +: 4] = 4'd0;
      run_tile(9'h1FC, p, 1'b0, 16'hFFFF, 1, 0, 0, -1);

      // Flip with alternating keep
      for (int k = 0; k < 16; k++) p[k*4 +: 4] = 4'(($urandom % 15) + 1);
      run_tile(9'h040, p, 1'b1, 16'hAAAA, 1, 0, 0, -1);
      check("flip_cnt", PIX_COUNT, 8);

      // Back-to-back with a stray LOAD at E5 in the first tile
      nxt_xs  = 9'h123;
      nxt_pix = rand_pix();
      nxt_flp = 1'b0;
      run_tile(9'h0F0, rand_pix(), 1'b1, 16'(($urandom)), 1, 1, 1, -1);
      run_tile(nxt_xs, nxt_pix, nxt_flp, 16'hFFFF, 0, 0, 0, -1);
      idle(2);

      // Reset before E7, then a fresh all-keep tile
      run_tile(9'h077, rand_pix(), 1'b0, 16'hFFFF, 1, 0, 0, 6);
      idle(2);
      for (int k = 0; k < 16; k++) p[k*4 +: 4] = 4'((k % 15) + 1);
      run_tile(9'h010, p, 1'b0, 16'hFFFF, 1, 0, 0, -1);

      // Random tiles with random chaining
      prev_chain = 1'b0;
      cur_xs  = 9'($urandom);
      cur_pix = rand_pix();
      cur_flp = 1'($urandom);
      for (int t = 0; t < 16; t++) begin
         chain   = (t < 15) && ($urandom % 2 == 1);
         nxt_xs  = 9'($urandom);
         nxt_pix = rand_pix();
         nxt_flp = 1'($urandom);
         run_tile(cur_xs, cur_pix, cur_flp, 16'($urandom), !prev_chain, chain,
                  ($urandom % 4 == 0), -1);
         prev_chain = chain;
         cur_xs  = nxt_xs;
         cur_pix = nxt_pix;
         cur_flp = nxt_flp;
         if (!chain && ($urandom % 2 == 1)) idle(1);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule

// File: doc/sprite_pixel_writer.md
Name: sprite_pixel_writer

Overview:
- Consumer end of the horizontal-shrink enable stream: takes one 16-pixel sprite tile row and the serial shrink enable bits, one per pixel, most significant pattern bit first.
- Writes only enabled pixels into the sprite line buffer at consecutive X addresses, which compacts the tile to its shrunk width.
- Sits between the tile fetch/decode path and the line buffer write port, in step with the shrink pattern generator. Both blocks are loaded by the same LOAD strobe.

Parameters:
- ADDR_W, 9, line buffer X address width; addresses wrap modulo 2^ADDR_W.
- PIX_W, 4, bits per pixel colour index.

Ports:
- CK  in  1  system clock; all state changes on the rising edge.
- nRESET  in  1  asynchronous, active-low reset.
- LOAD  in  1  start a tile; same strobe that loads the shrink pattern generator.
- SHRINK_BIT  in  1  serial enable for the current pixel; 1 = keep pixel, 0 = drop pixel.
- X_START  in  ADDR_W  line buffer X address of the first kept pixel; captured on LOAD.
- PIXELS  in  16*PIX_W  tile row; pixel k occupies bits [k*PIX_W +: PIX_W]; captured on LOAD.
- FLIP  in  1  horizontal flip; captured on LOAD.
- LB_WE  out  1  line buffer write enable (registered).
- LB_ADDR  out  ADDR_W  line buffer write address (registered).
- LB_DATA  out  PIX_W  colour index to write (registered).
- BUSY  out  1  tile in progress.
- DONE  out  1  one-cycle pulse after the last pixel has been processed.
- PIX_COUNT  out  5  number of kept pixels in the finished tile (0..16); valid while DONE=1 and held until the next DONE.

Behaviour:
- Reset (nRESET low, asynchronous):
  - state = IDLE.
  - LB_WE, LB_ADDR, LB_DATA, BUSY, DONE and PIX_COUNT all 0.
  - Internal X pointer and pixel counter are 0.
- States:
  - IDLE: waiting for LOAD.
  - RUN: 16 cycles, pixel index n = 0..15.
- Load: edge E0 samples LOAD=1 while in IDLE.
  - Captures X_START, PIXELS and FLIP.
  - Goes to RUN with n=0 and kept-pixel counter = 0.
  - BUSY=1 from E0.
- RUN, edge E(n+1), for n = 0..15:
  - Pixel select: source index s = n, or s = 15-n when FLIP=1.
  - If SHRINK_BIT=1:
    - LB_ADDR <= X pointer; LB_DATA <= pixel s.
    - LB_WE <= 1 if pixel s is nonzero. Colour 0 is transparent: no write, but the address still advances.
    - X pointer increments (wraps 2^ADDR_W-1 -> 0).
    - Kept-pixel counter increments.
  - If SHRINK_BIT=0: LB_WE <= 0; LB_ADDR and LB_DATA hold; X pointer holds.
  - Latency: the write for pixel n is visible from E(n+1) to E(n+2).
- End of tile, at E16:
  - DONE <= 1 for one cycle.
  - PIX_COUNT <= final kept count, including a keep on pixel 15.
  - If LOAD=0: state = IDLE, BUSY <= 0.
  - After the LB_* update for pixel 15, LB_WE <= 0 at E17.
- Back-to-back tiles: LOAD sampled at E16 (last RUN edge) starts the next tile with no gap. BUSY stays 1 and E17 processes pixel 0 of the new tile.
- LOAD while in RUN and not on the last edge is ignored; captured data and the count are unchanged.
- SHRINK_BIT is ignored in IDLE.
- Reset mid-RUN aborts immediately; no DONE is produced.

Decomposition:
- Shared package (sprite_pkg):
  - TILE_W = 16 and TRANSPARENT = 0.
  - State enum {IDLE, RUN}.
  - Default ADDR_W and PIX_W.
- One sub-module: sprite_pixel_select, a combinational 16:1 PIX_W-bit mux with flip. It returns the selected pixel and a transparent flag.
- The FSM, counters and output registers stay in the top module.

Test Plan:
- All-keep: SHRINK_BIT=1 for 16 cycles, X_START=0x010, PIXELS pixel k = (k%15)+1, FLIP=0 -> 16 writes, LB_ADDR 0x010..0x01F, LB_DATA 1..F,1; DONE at E16; PIX_COUNT=16.
- Max shrink: stream 0000000010000000 (MSB first) -> exactly one write at E9 (pixel 8), LB_ADDR = X_START; PIX_COUNT=1.
- Wrap and transparency: X_START=0x1FC, all-keep stream, pixel 2 = 0 -> addresses 0x1FC..0x1FF, 0x000..0x00B; LB_WE=0 only for address 0x1FE.
- Flip: FLIP=1, stream 1010101010101010 -> 8 writes of pixels 15, 13, ..., 1 at X_START..X_START+7; PIX_COUNT=8.
- Back-to-back: second LOAD at E16 -> BUSY stays 1, DONE pulses at E16 and E32, and the X pointer restarts from the second X_START. A LOAD at E5 is ignored.
- Reset mid-tile: nRESET low at E7 -> all outputs 0 immediately; no DONE. After release, a fresh LOAD behaves as in the all-keep case.
